hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central stall/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Consumes the D-stage Tuse/RES classification and register fields each cycle.
- Keeps its own shadow pipeline of destination register and Tnew for the E/M/W stages.
- Drives the global stall, the E-stage bubble insert and every forwarding mux select.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start (used only with HZ_MD_STALL_EN).
- DIV_CYC, 10, busy cycles after a div/divu start (used only with HZ_MD_STALL_EN).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- d_tuse_rs  in  2  Tuse of D rs: 0, 1, 2, 3=no use.
- d_tuse_rt  in  2  Tuse of D rt, same encoding.
- d_rs  in  5  D instruction rs.
- d_rt  in  5  D instruction rt.
- d_res  in  3  result source of D instruction: 0=NO, 1=ALU, 2=DM, 3=PC.
- d_a3  in  5  D destination register (already muxed rd/rt/31).
- d_md_start  in  1  D instruction is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: 1=div class.
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- stall  out  1  freeze PC and the F/D register.
- e_clr  out  1  load a bubble into D/E.
- fwd_d_rs  out  2  D rs compare/jr mux: 0=GRF, 1=E(PC+8), 2=M, 3=W.
- fwd_d_rt  out  2  same encoding for D rt.
- fwd_e_rs  out  2  ALU A mux: 0=reg, 2=M, 3=W.
- fwd_e_rt  out  2  ALU B / store-data mux: 0=reg, 2=M, 3=W.
- fwd_m_rt  out  1  DM write data: 0=reg, 1=W.
- md_busy  out  1  multiply/divide unit busy; 0 when feature is compiled out.

Behaviour:
- Shadow stage records: E{rs, rt, a3, tnew}, M{rt, a3, tnew}, W{a3}.
  - Records advance every clock edge; W <- M, M <- E.
  - tnew decrements by one per advance and saturates at 0.
- E load on the edge:
  - When stall=0, E takes {d_rs, d_rt, a3', tnew'}.
  - tnew' = 1 for ALU, 2 for DM, 0 for PC, 0 for NO.
  - a3' = d_a3, forced to 0 when d_res=NO.
  - When stall=1, E loads a bubble (all fields 0); M and W still advance.
- Stall equation (combinational):
  - stall_rs = tuse_rs≠3 AND rs≠0 AND ((E.a3=rs AND E.tnew>tuse_rs) OR (M.a3=rs AND M.tnew>tuse_rs)). stall_rt is identical with rt.
  - stall = stall_rs | stall_rt | stall_md.
  - e_clr = stall.
- Forwarding priority is youngest first: E > M > W. Every match requires a3≠0.
  - D readers: E only when E.tnew=0 (PC result); then M when M.tnew=0; then W.
  - E readers: M when M.tnew=0, else W.
  - M rt: W.
  - A match on a stage whose tnew>0 must not forward and must not fall through to an older stage. Stall covers this case.
- Register $0 never forwards and never stalls.
- Reset:
  - All shadow records clear to 0 immediately on reset low, independent of clk.
  - All outputs go to 0; the md counter clears to 0.
  - A reset during a stall or an md operation aborts it.
  - The first edge after reset release behaves as normal pipeline operation.
- All outputs are combinational from registered state plus D inputs. Zero added latency.

Optional Feature:
- Macro HZ_MD_STALL_EN.
- With the macro defined:
  - A 4-bit down-counter loads MULT_CYC or DIV_CYC when the E stage holds an md start. The start flag is pipelined as E.md/E.div.
  - md_busy = counter≠0 OR E.md.
  - stall_md = d_md_use AND md_busy.
  - The counter decrements to 0 and holds there.
  - A new start while busy reloads the counter. This case is unreachable because of the stall.
- Without the macro: stall_md=0, md_busy=0, the counter logic is absent, and d_md_* inputs are ignored.

Decomposition:
- Shared package/define holds:
  - Tuse codes TUSE_0/1/2/NO.
  - RES codes RES_NO/ALU/DM/PC.
  - FWD select codes FWD_REG/E/M/W.
  - The Tnew-from-RES mapping constants.
- One natural sub-module: hz_fwd_sel. It is purely combinational, instantiated five times, and maps {reg, stage a3/tnew} to a select value.

Test Plan:
- lw $1 in E (tnew=2), D beq $1,$2 (tuse_rs=0) -> stall=1, e_clr=1 for 2 cycles, then fwd_d_rs=2 (M) is not possible because M.tnew=1; fwd_d_rs=3 (W) on the third cycle with stall=0.
- addu $3 in E, D ori rs=$3 (tuse=1) -> no stall; next cycle fwd_e_rs=2 (M).
- jal in E (a3=31, tnew=0), D jr $31 -> stall=0, fwd_d_rs=1.
- Writes to $0 in E/M/W, D reads $0 with tuse=0 -> stall=0, all fwd=0.
- lw $5 in M, sw $5 in E -> fwd_e_rt=0; next cycle fwd_m_rt=1.
- With HZ_MD_STALL_EN: div enters E, mflo in D on the following cycles -> stall=1 for exactly DIV_CYC+1 cycles. Asserting reset mid-count -> md_busy=0 immediately.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared Tuse/RES/forward codes and Tnew mapping for hazard_ctrl
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    TUSE_0  = 2'd0,
    TUSE_1  = 2'd1,
    TUSE_2  = 2'd2,
    TUSE_NO = 2'd3
  } tuse_t;

  typedef enum logic [2:0] {
    RES_NO  = 3'd0,
    RES_ALU = 3'd1,
    RES_DM  = 3'd2,
    RES_PC  = 3'd3
  } res_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_t;

  localparam logic [1:0] TNEW_NO  = 2'd0;
  localparam logic [1:0] TNEW_ALU = 2'd1;
  localparam logic [1:0] TNEW_DM  = 2'd2;
  localparam logic [1:0] TNEW_PC  = 2'd0;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
  } e_rec_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
  } m_rec_t;

  function automatic logic [1:0] tnew_of(input logic [2:0] res);
    case (res)
      RES_ALU: return TNEW_ALU;
      RES_DM:  return TNEW_DM;
      RES_PC:  return TNEW_PC;
      default: return TNEW_NO;
    endcase
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - one forwarding mux select, youngest matching stage wins
import hazard_ctrl_pkg::*;

module hz_fwd_sel (
  input  logic [4:0] src,
  input  logic       e_en,
  input  logic [4:0] e_a3,
  input  logic [1:0] e_tnew,
  input  logic       m_en,
  input  logic [4:0] m_a3,
  input  logic [1:0] m_tnew,
  input  logic [4:0] w_a3,
  output logic [1:0] sel
);

  // A match on a not-yet-ready stage blocks older stages; the stall covers it.
  always_comb begin
    sel = FWD_REG;
    if (src == 5'd0) begin
      sel = FWD_REG;
    end else if (e_en && e_a3 == src) begin
      sel = (e_tnew == 2'd0) ? FWD_E : FWD_REG;
    end else if (m_en && m_a3 == src) begin
      sel = (m_tnew == 2'd0) ? FWD_M : FWD_REG;
    end else if (w_a3 == src) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/forward controller for the 5-stage pipeline; md stall under HZ_MD_STALL_EN
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [2:0] d_res,
  input  logic [4:0] d_a3,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic       e_clr,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt,
  output logic       md_busy
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  e_rec_t     e_q, e_d;
  m_rec_t     m_q;
  logic [4:0] w_a3_q;
  logic       stall_rs, stall_rt, stall_md;
  logic [1:0] m_rt_sel;

  always_comb begin
    stall_rs = (d_tuse_rs != TUSE_NO) && (d_rs != 5'd0) &&
               ((e_q.a3 == d_rs && e_q.tnew > d_tuse_rs) ||
                (m_q.a3 == d_rs && m_q.tnew > d_tuse_rs));
    stall_rt = (d_tuse_rt != TUSE_NO) && (d_rt != 5'd0) &&
               ((e_q.a3 == d_rt && e_q.tnew > d_tuse_rt) ||
                (m_q.a3 == d_rt && m_q.tnew > d_tuse_rt));
    stall    = stall_rs | stall_rt | stall_md;
    e_clr    = stall;
  end

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs   = d_rs;
      e_d.rt   = d_rt;
      e_d.a3   = (d_res == RES_NO) ? 5'd0 : d_a3;
      e_d.tnew = tnew_of(d_res);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_a3_q <= '0;
    end else begin
      e_q     <= e_d;
      m_q.rt   <= e_q.rt;
      m_q.a3   <= e_q.a3;
      m_q.tnew <= tnew_dec(e_q.tnew);
      w_a3_q  <= m_q.a3;
    end
  end

`ifdef HZ_MD_STALL_EN
  logic       e_md_q, e_div_q;
  logic [3:0] md_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_md_q   <= 1'b0;
      e_div_q  <= 1'b0;
      md_cnt_q <= 4'd0;
    end else begin
      e_md_q  <= !stall && d_md_start;
      e_div_q <= !stall && d_md_start && d_md_div;
      if (e_md_q)
        md_cnt_q <= e_div_q ? DIV_LD : MULT_LD;
      else if (md_cnt_q != 4'd0)
        md_cnt_q <= md_cnt_q - 4'd1;
    end
  end

  assign md_busy  = (md_cnt_q != 4'd0) || e_md_q;
  assign stall_md = d_md_use && md_busy;
`else
  logic unused_md;
  assign unused_md = ^{d_md_start, d_md_div, d_md_use, MULT_LD, DIV_LD};
  assign md_busy   = 1'b0;
  assign stall_md  = 1'b0;
`endif

  hz_fwd_sel u_fwd_d_rs (
    .src(d_rs), .e_en(1'b1), .e_a3(e_q.a3), .e_tnew(e_q.tnew),
    .m_en(1'b1), .m_a3(m_q.a3), .m_tnew(m_q.tnew), .w_a3(w_a3_q), .sel(fwd_d_rs)
  );

  hz_fwd_sel u_fwd_d_rt (
    .src(d_rt), .e_en(1'b1), .e_a3(e_q.a3), .e_tnew(e_q.tnew),
    .m_en(1'b1), .m_a3(m_q.a3), .m_tnew(m_q.tnew), .w_a3(w_a3_q), .sel(fwd_d_rt)
  );

  hz_fwd_sel u_fwd_e_rs (
    .src(e_q.rs), .e_en(1'b0), .e_a3(5'd0), .e_tnew(2'd0),
    .m_en(1'b1), .m_a3(m_q.a3), .m_tnew(m_q.tnew), .w_a3(w_a3_q), .sel(fwd_e_rs)
  );

  hz_fwd_sel u_fwd_e_rt (
    .src(e_q.rt), .e_en(1'b0), .e_a3(5'd0), .e_tnew(2'd0),
    .m_en(1'b1), .m_a3(m_q.a3), .m_tnew(m_q.tnew), .w_a3(w_a3_q), .sel(fwd_e_rt)
  );

  hz_fwd_sel u_fwd_m_rt (
    .src(m_q.rt), .e_en(1'b0), .e_a3(5'd0), .e_tnew(2'd0),
    .m_en(1'b0), .m_a3(5'd0), .m_tnew(2'd0), .w_a3(w_a3_q), .sel(m_rt_sel)
  );

  assign fwd_m_rt = (m_rt_sel == FWD_W);

endmodule
